// File: rtl/imem_stream_loader.sv
// Instruction-memory loader: parses a host byte stream (count, words, checksum)
// and writes 16-bit words into instruction memory while holding the processor.
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        write_enable,
  output logic [31:0] write_addr,
  output logic [15:0] write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

  state_t      state_reg;
  logic [15:0] count_reg;
  logic [31:0] index_reg;
  logic [7:0]  hi_reg;
  logic [7:0]  xor_reg;

  logic        accept;
  logic [15:0] count_full;
  logic [31:0] last_index;

  assign accept     = byte_valid && byte_ready;
  assign count_full = {count_reg[15:8], byte_in};
  // Only consulted in DATA_LO, where the count is known to be non-zero.
  assign last_index = {16'd0, count_reg} - 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      index_reg    <= '0;
      hi_reg       <= '0;
      xor_reg      <= '0;
      byte_ready   <= 1'b0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_reg  <= CNT_HI;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            xor_reg    <= '0;
          end
        end
        CNT_HI: begin
          if (accept) begin
            count_reg[15:8] <= byte_in;
            xor_reg         <= xor_reg ^ byte_in;
            state_reg       <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            count_reg <= count_full;
            xor_reg   <= xor_reg ^ byte_in;
            index_reg <= '0;
            // An oversize count aborts at once; its checksum byte is never taken.
            if ({16'd0, count_full} > MAX_WORDS) begin
              state_reg  <= ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else if (count_full == 16'd0) begin
              state_reg <= CHECK;
            end else begin
              state_reg <= DATA_HI;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_reg    <= byte_in;
            xor_reg   <= xor_reg ^ byte_in;
            state_reg <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            write_enable <= 1'b1;
            write_addr   <= BASE_ADDR + index_reg;
            write_data   <= {hi_reg, byte_in};
            index_reg    <= index_reg + 32'd1;
            xor_reg      <= xor_reg ^ byte_in;
            state_reg    <= (index_reg == last_index) ? CHECK : DATA_HI;
          end
        end
        CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_in == xor_reg) begin
              state_reg <= DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_reg  <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state_reg  <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized scoreboard bench for imem_stream_loader: a stream-level model
// predicts the memory writes and the final status of every load session.
module tb_imem_stream_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MEMW = 1024;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [15:0] write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t exp_q[$];

  imem_stream_loader #(.BASE_ADDR(BASE), .MEM_WORDS(MEMW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", write_addr, write_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", write_addr, e.a);
        check("write_data", 32'(write_data), 32'(e.d));
        $display("write addr=%0h data=%0h", write_addr, write_data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if ($urandom_range(0, 2) == 0) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (byte_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: byte_ready=%b for byte %0h, required 1", byte_ready, b);
    end else begin
      @(negedge clk);
    end
  endtask

  function automatic byte_q_t build(input int n, input bit bad);
    byte_q_t     q;
    logic [15:0] n16 = 16'(n);
    logic [7:0]  x = 8'h00;
    q.push_back(n16[15:8]);
    q.push_back(n16[7:0]);
    if (n <= MEMW) begin
      for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
      foreach (q[i]) x ^= q[i];
      q.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    end
    return q;
  endfunction

  // Reference: predict writes, bytes consumed and outcome from the stream rules.
  task automatic run_session(input byte_q_t s, input int mid_start);
    int         n;
    int         consumed;
    bit         exp_done;
    logic [7:0] x;
    wr_t        w;
    n = {s[0], s[1]};
    if (n > MEMW) begin
      consumed = 2;
      exp_done = 1'b0;
    end else begin
      for (int k = 0; k < n; k++) begin
        w.a = BASE + 32'(k);
        w.d = {s[2 + 2 * k], s[3 + 2 * k]};
        exp_q.push_back(w);
      end
      x = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) x ^= s[i];
      exp_done = (s[2 + 2 * n] == x);
      consumed = 3 + 2 * n;
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_clears_status", {30'd0, load_done, load_error}, 32'd0);
    check("start_ready", 32'(byte_ready), 32'd1);

    for (int i = 0; i < consumed; i++) begin
      if (i == mid_start) begin
        byte_valid = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(s[i]);
    end
    byte_valid = 1'b0;
    check("end_ready_low", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("load_done", 32'(load_done), 32'(exp_done));
    check("load_error", 32'(load_error), 32'(!exp_done));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    $display("session n=%0d bytes=%0d done=%b error=%b hold=%b", n, consumed, load_done, load_error, cpu_hold);
    exp_q.delete();
  endtask

  initial begin
    byte_q_t s;
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {byte_ready, write_enable, cpu_hold, load_done, load_error}, 32'd0);
    check("reset_addr", write_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}; run_session(s, -1);
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}; run_session(s, -1);
    s = '{8'h04, 8'h01};                                    run_session(s, -1);
    s = '{8'h00, 8'h00, 8'h00};                             run_session(s, -1);
    s = '{8'h00, 8'h00, 8'h01};                             run_session(s, -1);
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};               run_session(s, -1);
    s = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h06};               run_session(s, 3);

    for (int r = 0; r < 8; r++) begin
      s = build($urandom_range(0, 6), $urandom_range(0, 3) == 0);
      run_session(s, (r % 2 == 1) ? int'($urandom_range(1, 2)) : -1);
    end
    s = build($urandom_range(MEMW + 1, 65535), 1'b0); run_session(s, -1);
    s = build(MEMW, 1'b0);                            run_session(s, -1);
    s = build(MEMW + 1, 1'b0);                        run_session(s, -1);

    // Asynchronous reset in the middle of a session.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h03);
    byte_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {byte_ready, write_enable, cpu_hold, load_done, load_error}, 32'd0);
    check("async_reset_addr", write_addr, 32'd0);
    check("async_reset_data", 32'(write_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    byte_in    = 8'h5A;
    byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    byte_valid = 1'b0;
    check("post_reset_idle", {byte_ready, cpu_hold, load_done, load_error}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
